// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer for a downstream 4:1 mux: grants requesting channels in turn,
// holds each grant for DWELL cycles and captures the fed-back mux output per channel.
module mux_rr_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       y,
  output logic [1:0] sel,
  output logic       valid,
  output logic [3:0] sample,
  output logic       cap_valid,
  output logic [1:0] cap_ch
);

  // Handshake: valid is high exactly while sel carries a granted channel; there is no
  // ready, the downstream mux is always listening. cap_valid is a one-cycle strobe that
  // qualifies cap_ch and the freshly written sample bit; no back-pressure exists.

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_CNT = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_d;
  logic       valid_d;
  logic [3:0] sample_d;
  logic       cap_valid_d;
  logic [1:0] cap_ch_d;
  logic [1:0] pick_idle, pick_end;

  // First requester found scanning upward from the channel after l, wrapping at 3.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    rr_pick = l;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick_idle = rr_pick(req, last_q);
  assign pick_end  = rr_pick(req, sel);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    sel_d       = sel;
    valid_d     = valid;
    sample_d    = sample;
    cap_valid_d = 1'b0;
    cap_ch_d    = cap_ch;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (req != 4'b0000) begin
          sel_d   = pick_idle;
          valid_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q == LAST_CNT) begin
          sample_d[sel] = y;
          cap_ch_d      = sel;
          cap_valid_d   = 1'b1;
          last_d        = sel;
          cnt_d         = 4'd0;
          // Re-arbitrate on the same edge so consecutive grants have no bubble.
          if (req != 4'b0000) begin
            sel_d = pick_end;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      cnt_q     <= 4'd0;
      sel       <= 2'd0;
      valid     <= 1'b0;
      sample    <= 4'b0000;
      cap_valid <= 1'b0;
      cap_ch    <= 2'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      sel       <= sel_d;
      valid     <= valid_d;
      sample    <= sample_d;
      cap_valid <= cap_valid_d;
      cap_ch    <= cap_ch_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Bench for mux_rr_sequencer: DWELL=4 and DWELL=1 instances, each feeding back a modelled
// 4:1 mux, checked against a timestamp-style grant model and a capture queue.
module tb_mux_rr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req4, data4, req1, data1;
  logic       y4, y1;
  logic [1:0] sel4, sel1, cap_ch4, cap_ch1;
  logic       valid4, valid1, cap_valid4, cap_valid1;
  logic [3:0] sample4, sample1;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_cap;

  typedef struct {
    bit         active;
    int         ch;
    int         last;
    int         left;
    logic [3:0] sample;
    bit         cap_valid;
    int         cap_ch;
  } model_t;

  model_t m4, m1;

  always #5 clk = ~clk;

  assign y4 = data4[sel4];
  assign y1 = data1[sel1];

  mux_rr_sequencer #(.DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .y(y4), .sel(sel4), .valid(valid4),
    .sample(sample4), .cap_valid(cap_valid4), .cap_ch(cap_ch4)
  );

  mux_rr_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .y(y1), .sel(sel1), .valid(valid1),
    .sample(sample1), .cap_valid(cap_valid1), .cap_ch(cap_ch1)
  );

  function automatic model_t model_reset();
    model_t m;
    m.active = 0; m.ch = 0; m.last = 3; m.left = 0;
    m.sample = 4'b0000; m.cap_valid = 0; m.cap_ch = 0;
    return m;
  endfunction

  // One rising edge: finish the current grant if its time is up, then pick the next one.
  function automatic model_t model_next(model_t m, logic [3:0] r, logic [3:0] d, int dwell);
    model_t n = m;
    n.cap_valid = 0;
    if (m.active && m.left == 1) begin
      n.sample[m.ch] = d[m.ch];
      n.cap_valid = 1;
      n.cap_ch = m.ch;
      n.last = m.ch;
      n.active = 0;
    end else if (m.active) begin
      n.left = m.left - 1;
    end
    if (!n.active) begin
      for (int i = 1; i <= 4; i++) begin
        int c = (n.last + i) % 4;
        if (!n.active && r[c]) begin
          n.active = 1;
          n.ch = c;
          n.left = dwell;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [9:0] exp_vec(model_t m);
    return {2'(m.ch), m.active, m.sample, m.cap_valid, 2'(m.cap_ch)};
  endfunction

  function automatic logic [9:0] act4();
    return {sel4, valid4, sample4, cap_valid4, cap_ch4};
  endfunction

  function automatic logic [9:0] act1();
    return {sel1, valid1, sample1, cap_valid1, cap_ch1};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      m4 = model_next(m4, req4, data4, 4);
      m1 = model_next(m1, req1, data1, 1);
      if (m4.cap_valid) exp_q.push_back({2'(m4.cap_ch), m4.sample[m4.cap_ch]});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req4 = 4'b0000; req1 = 4'b0000; data4 = 4'b0000; data1 = 4'b0000;
    m4 = model_reset();
    m1 = model_reset();
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req4 = 4'b1111; req1 = 4'b1111; data4 = 4'b1111; data1 = 4'b1111;
    m4 = model_reset();
    m1 = model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (act4() !== 10'b0) begin
        n_err++;
        $display("FAIL reset_hold4 cycle %0d: got %b want %b", i, act4(), 10'b0);
      end
      n_vec++;
      if (act1() !== 10'b0) begin
        n_err++;
        $display("FAIL reset_hold1 cycle %0d: got %b want %b", i, act1(), 10'b0);
      end
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if ({sel4, valid4} !== 3'b001) begin
      n_err++;
      $display("FAIL reset_first_grant: got sel=%0d valid=%b want sel=0 valid=1", sel4, valid4);
    end
  endtask

  task automatic test_single();
    do_reset();
    req4 = 4'b0100;
    data4 = 4'b0100;
    step();
    req4 = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      n_vec++;
      if (act4() !== exp_vec(m4)) begin
        n_err++;
        $display("FAIL single_model step %0d: got %b want %b", i, act4(), exp_vec(m4));
      end
      if (i == 5) begin
        n_vec++;
        if ({cap_valid4, cap_ch4, sample4, valid4} !== 8'b1_10_0100_0) begin
          n_err++;
          $display("FAIL single_capture: got cv=%b ch=%0d sample=%b valid=%b want cv=1 ch=2 sample=0100 valid=0",
                   cap_valid4, cap_ch4, sample4, valid4);
        end
      end
      step();
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req4 = 4'b1111;
    data4 = 4'b1010;
    for (int i = 1; i <= 17; i++) begin
      step();
      n_vec++;
      if (act4() !== exp_vec(m4) || valid4 !== 1'b1) begin
        n_err++;
        $display("FAIL rotation_model step %0d: got %b want %b", i, act4(), exp_vec(m4));
      end
      if (cap_valid4 === 1'b1) begin
        n_vec++;
        exp_cap = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        if ({cap_ch4, sample4[cap_ch4]} !== exp_cap) begin
          n_err++;
          $display("FAIL rotation_capture: got %b want %b", {cap_ch4, sample4[cap_ch4]}, exp_cap);
        end
      end
    end
    n_vec++;
    if (sample4 !== 4'b1010) begin
      n_err++;
      $display("FAIL rotation_sample: got %b want 1010", sample4);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req4 = 4'b1000;
    data4 = 4'($urandom_range(0, 15));
    step();
    req4 = 4'b0011;
    for (int i = 1; i <= 21; i++) begin
      step();
      n_vec++;
      if (act4() !== exp_vec(m4)) begin
        n_err++;
        $display("FAIL wrap_model step %0d: got %b want %b", i, act4(), exp_vec(m4));
      end
      if (i == 4 || i == 8 || i == 12 || i == 16 || i == 20) begin
        logic [1:0] want;
        want = (i == 4 || i == 12) ? 2'd0 : (i == 8) ? 2'd1 : 2'd3;
        n_vec++;
        if (sel4 !== want || valid4 !== 1'b1) begin
          n_err++;
          $display("FAIL wrap_order step %0d: got sel=%0d valid=%b want sel=%0d valid=1", i, sel4, valid4, want);
        end
      end
      if (i == 12) req4 = 4'b1000;
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req4 = 4'b0010;
    data4 = 4'b0010;
    step();
    step();
    #2;
    rst_n = 1'b0;
    m4 = model_reset();
    m1 = model_reset();
    exp_q.delete();
    #1;
    n_vec++;
    if (act4() !== 10'b0) begin
      n_err++;
      $display("FAIL midreset_immediate: got %b want %b", act4(), 10'b0);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (cap_valid4 !== 1'b0 || sample4[1] !== 1'b0 || valid4 !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_hold: got cv=%b sample=%b valid=%b want 0 0000 0", cap_valid4, sample4, valid4);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_dwell1();
    do_reset();
    req1 = 4'b0101;
    data1 = 4'($urandom_range(0, 15));
    for (int i = 1; i <= 10; i++) begin
      step();
      n_vec++;
      if (act1() !== exp_vec(m1)) begin
        n_err++;
        $display("FAIL dwell1_model step %0d: got %b want %b", i, act1(), exp_vec(m1));
      end
      n_vec++;
      if (sel1 !== ((i % 2 == 1) ? 2'd0 : 2'd2) || (i >= 2 && cap_valid1 !== 1'b1)) begin
        n_err++;
        $display("FAIL dwell1_alternate step %0d: got sel=%0d cv=%b", i, sel1, cap_valid1);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req4 = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      req1 = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      data4 = 4'($urandom_range(0, 15));
      data1 = 4'($urandom_range(0, 15));
      step();
      n_vec++;
      if (act4() !== exp_vec(m4)) begin
        n_err++;
        $display("FAIL random4 step %0d: got %b want %b", i, act4(), exp_vec(m4));
      end
      n_vec++;
      if (act1() !== exp_vec(m1)) begin
        n_err++;
        $display("FAIL random1 step %0d: got %b want %b", i, act1(), exp_vec(m1));
      end
      if (cap_valid4 === 1'b1) begin
        n_vec++;
        exp_cap = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        if ({cap_ch4, sample4[cap_ch4]} !== exp_cap) begin
          n_err++;
          $display("FAIL random_capture step %0d: got %b want %b", i, {cap_ch4, sample4[cap_ch4]}, exp_cap);
        end
      end
    end
    n_vec++;
    if (exp_q.size() > 1) begin
      n_err++;
      $display("FAIL random_drain: %0d captures expected but not seen", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_reset_mid_grant();
    test_dwell1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
